// File: rtl/enemy_manager_if.sv
// Signal bundle between enemy_manager and its frame/collision environment.
// The slave side belongs to the manager, the master side to whoever drives frames and hits.
interface enemy_manager_if #(
  parameter int unsigned NUM_ENEMIES = 4
);
  logic                       startOfFrame;
  logic                       game_start;
  logic [NUM_ENEMIES-1:0]     enemy_hit;
  logic [4*NUM_ENEMIES-1:0]   dir_code;
  logic [NUM_ENEMIES-1:0]     random;
  logic [NUM_ENEMIES-1:0]     enemy_alive;
  logic [NUM_ENEMIES-1:0]     enemy_dying;
  logic                       kill_pulse;
  logic                       level_clear;

  modport slave (
    input  startOfFrame, game_start, enemy_hit,
    output dir_code, random, enemy_alive, enemy_dying, kill_pulse, level_clear
  );

  modport master (
    output startOfFrame, game_start, enemy_hit,
    input  dir_code, random, enemy_alive, enemy_dying, kill_pulse, level_clear
  );
endinterface

// File: rtl/enemy_manager.sv
// Tracks alive/dying state and movement direction for each enemy, sweeping one enemy per
// cycle after every frame pulse; emits kill pulses and a level-clear flag.
module enemy_manager #(
  parameter int unsigned NUM_ENEMIES  = 4,
  parameter int unsigned TURN_PERIOD  = 32,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int unsigned DEATH_FRAMES = 16
) (
  input  logic           clk,
  input  logic           resetN,
  enemy_manager_if.slave bus
);

  localparam int unsigned IdxW   = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
  localparam int unsigned TurnW  = (TURN_PERIOD > 1) ? $clog2(TURN_PERIOD) : 1;
  localparam int unsigned DeathW = $clog2(DEATH_FRAMES + 1);
  localparam int unsigned Phase  = TURN_PERIOD / NUM_ENEMIES;

  localparam logic [3:0] DirStop   = 4'b0000;
  localparam logic [3:0] DirTop    = 4'b0100;
  localparam logic [3:0] DirRight  = 4'b0010;
  localparam logic [3:0] DirLeft   = 4'b1000;
  localparam logic [3:0] DirBottom = 4'b0001;

  typedef enum logic [1:0] {StIdle, StRun, StUpdate, StCheck} state_e;

  state_e                                state_q, state_d;
  logic [IdxW-1:0]                       idx_q, idx_d;
  logic [15:0]                           lfsr_q, lfsr_d;
  logic [NUM_ENEMIES-1:0]                alive_q, alive_d;
  logic [NUM_ENEMIES-1:0]                dying_q, dying_d;
  logic [NUM_ENEMIES-1:0]                pend_q, pend_d;
  logic [NUM_ENEMIES-1:0]                rand_q, rand_d;
  logic [NUM_ENEMIES-1:0][3:0]           dir_q, dir_d;
  logic [NUM_ENEMIES-1:0][TurnW-1:0]     turn_q, turn_d;
  logic [NUM_ENEMIES-1:0][DeathW-1:0]    death_q, death_d;
  logic                                  kill_q, kill_d;
  logic                                  clear_q, clear_d;

  function automatic logic [3:0] dir_from_bits(input logic [1:0] sel);
    logic [3:0] d;
    unique case (sel)
      2'b00:   d = DirTop;
      2'b01:   d = DirRight;
      2'b10:   d = DirLeft;
      default: d = DirBottom;
    endcase
    return d;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    alive_d = alive_q;
    dying_d = dying_q;
    rand_d  = rand_q;
    dir_d   = dir_q;
    turn_d  = turn_q;
    death_d = death_q;
    kill_d  = 1'b0;
    clear_d = clear_q;
    // Hits on live enemies are latched in any cycle and serviced in the next sweep.
    pend_d  = pend_q | (bus.enemy_hit & alive_q);
    lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    if (bus.game_start) begin
      alive_d = '1;
      dying_d = '0;
      pend_d  = '0;
      clear_d = 1'b0;
      idx_d   = '0;
      state_d = StRun;
      for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
        dir_d[i]   = DirBottom;
        // Counter holds frames-to-turn minus one; staggers turns by Phase frames per enemy.
        turn_d[i]  = TurnW'(TURN_PERIOD - 1 - i * Phase);
        death_d[i] = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StRun: begin
          if (bus.startOfFrame) begin
            idx_d   = '0;
            state_d = StUpdate;
          end
        end
        StUpdate: begin
          for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
            if (idx_q == IdxW'(i)) begin
              if (pend_q[i]) begin
                alive_d[i] = 1'b0;
                dying_d[i] = 1'b1;
                dir_d[i]   = DirStop;
                death_d[i] = DeathW'(DEATH_FRAMES);
                pend_d[i]  = 1'b0;
                kill_d     = 1'b1;
              end else if (dying_q[i]) begin
                death_d[i] = death_q[i] - 1'b1;
                if (death_q[i] == DeathW'(1)) dying_d[i] = 1'b0;
              end else if (alive_q[i]) begin
                if (turn_q[i] == '0) begin
                  turn_d[i] = TurnW'(TURN_PERIOD - 1);
                  dir_d[i]  = dir_from_bits(lfsr_q[1:0]);
                  rand_d[i] = lfsr_q[2];
                end else begin
                  turn_d[i] = turn_q[i] - 1'b1;
                end
              end
            end
          end
          if (idx_q == IdxW'(NUM_ENEMIES - 1)) state_d = StCheck;
          else                                  idx_d   = idx_q + 1'b1;
        end
        StCheck: begin
          if (alive_q == '0 && dying_q == '0) begin
            clear_d = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StRun;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_q <= StIdle;
      idx_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      alive_q <= '0;
      dying_q <= '0;
      pend_q  <= '0;
      rand_q  <= '0;
      dir_q   <= '0;
      turn_q  <= '0;
      death_q <= '0;
      kill_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      alive_q <= alive_d;
      dying_q <= dying_d;
      pend_q  <= pend_d;
      rand_q  <= rand_d;
      dir_q   <= dir_d;
      turn_q  <= turn_d;
      death_q <= death_d;
      kill_q  <= kill_d;
      clear_q <= clear_d;
    end
  end

  assign bus.dir_code    = dir_q;
  assign bus.random      = rand_q;
  assign bus.enemy_alive = alive_q;
  assign bus.enemy_dying = dying_q;
  assign bus.kill_pulse  = kill_q;
  assign bus.level_clear = clear_q;

endmodule

// File: tb/tb_enemy_manager.sv
// Directed bench for enemy_manager: reset, re-arm, turn scheduling against a reference LFSR,
// kills, death timeout, level clear and asynchronous reset mid-sweep.
module tb_enemy_manager;

  localparam int NE = 4;

  logic clk = 1'b0;
  logic resetN;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   sof_cyc = 0;
  int   kills[$];
  logic [15:0] m_lfsr;
  logic [15:0] upd_lfsr [NE];
  logic [NE-1:0][3:0] exp_dir;
  logic [NE-1:0]      exp_rand;
  int   fire [NE] = '{32, 24, 16, 8};

  enemy_manager_if #(.NUM_ENEMIES(NE)) bus ();

  enemy_manager #(
    .NUM_ENEMIES (NE),
    .TURN_PERIOD (32),
    .LFSR_SEED   (16'hACE1),
    .DEATH_FRAMES(16)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, one step per clock.
  always @(posedge clk or posedge resetN) begin
    if (resetN) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  always @(negedge clk) if (bus.kill_pulse === 1'b1) kills.push_back(cyc);

  function automatic logic [3:0] ref_dir(input logic [1:0] sel);
    case (sel)
      2'b00:   return 4'b0100;
      2'b01:   return 4'b0010;
      2'b10:   return 4'b1000;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_game();
    @(negedge clk) bus.game_start = 1'b1;
    @(negedge clk) bus.game_start = 1'b0;
  endtask

  task automatic hit(input logic [NE-1:0] m);
    @(negedge clk) bus.enemy_hit = m;
    @(negedge clk) bus.enemy_hit = '0;
  endtask

  // One frame; snapshots the LFSR seen by each enemy's update cycle.
  task automatic frame();
    @(negedge clk) bus.startOfFrame = 1'b1;
    @(negedge clk) bus.startOfFrame = 1'b0;
    sof_cyc = cyc;
    for (int k = 0; k < NE; k++) begin
      upd_lfsr[k] = m_lfsr;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alive"}, 32'(bus.enemy_alive), 32'h0);
    check({tag, "_dying"}, 32'(bus.enemy_dying), 32'h0);
    check({tag, "_dir"},   32'(bus.dir_code),    32'h0);
    check({tag, "_rand"},  32'(bus.random),      32'h0);
    check({tag, "_kill"},  32'(bus.kill_pulse),  32'h0);
    check({tag, "_clear"}, 32'(bus.level_clear), 32'h0);
  endtask

  initial begin
    int k_first;
    int k_last;
    bus.startOfFrame = 1'b0;
    bus.game_start   = 1'b0;
    bus.enemy_hit    = '0;
    resetN           = 1'b0;
    #1 resetN = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    resetN = 1'b0;

    start_game();
    check("arm_alive", 32'(bus.enemy_alive), 32'hF);
    check("arm_dir",   32'(bus.dir_code),    32'h1111);
    check("arm_dying", 32'(bus.enemy_dying), 32'h0);
    check("arm_clear", 32'(bus.level_clear), 32'h0);

    // Turn schedule: enemy i re-rolls on frame 32 - 8*i.
    exp_dir  = 16'h1111;
    exp_rand = '0;
    kills.delete();
    for (int f = 1; f <= 32; f++) begin
      frame();
      for (int i = 0; i < NE; i++) begin
        if (f == fire[i]) begin
          exp_dir[i]  = ref_dir(upd_lfsr[i][1:0]);
          exp_rand[i] = upd_lfsr[i][2];
        end
      end
      check($sformatf("turn_dir_f%0d", f),  32'(bus.dir_code), 32'(exp_dir));
      check($sformatf("turn_rand_f%0d", f), 32'(bus.random),   32'(exp_rand));
      if (f == 2) begin
        check("f2_alive", 32'(bus.enemy_alive), 32'hF);
        check("f2_kills", 32'(kills.size()),    32'd0);
        check("f2_clear", 32'(bus.level_clear), 32'h0);
      end
    end

    // Single kill on enemy 2, pulse three cycles after the frame is taken.
    kills.delete();
    hit(4'b0100);
    frame();
    k_first = (kills.size() > 0) ? kills[0] : -1;
    check("k2_count", 32'(kills.size()),         32'd1);
    check("k2_when",  32'(k_first),              32'(sof_cyc + 3));
    check("k2_alive", 32'(bus.enemy_alive),      32'hB);
    check("k2_dying", 32'(bus.enemy_dying),      32'h4);
    check("k2_dir",   32'(bus.dir_code[11:8]),   32'h0);
    repeat (15) frame();
    check("k2_dying15", 32'(bus.enemy_dying), 32'h4);
    frame();
    check("k2_dying16", 32'(bus.enemy_dying), 32'h0);
    check("k2_alive16", 32'(bus.enemy_alive), 32'hB);

    // Re-arm with two dead and one pending hit: everything restored, pending dropped.
    kills.delete();
    hit(4'b0001);
    frame();
    check("k0_alive", 32'(bus.enemy_alive), 32'hA);
    check("k0_count", 32'(kills.size()),    32'd1);
    hit(4'b0010);
    start_game();
    check("rearm_alive", 32'(bus.enemy_alive), 32'hF);
    check("rearm_dying", 32'(bus.enemy_dying), 32'h0);
    check("rearm_dir",   32'(bus.dir_code),    32'h1111);
    check("rearm_clear", 32'(bus.level_clear), 32'h0);
    kills.delete();
    frame();
    check("rearm_nokill", 32'(kills.size()),    32'd0);
    check("rearm_alive2", 32'(bus.enemy_alive), 32'hF);

    // Kill all four at once, then run out the death timers to level clear.
    kills.delete();
    hit(4'hF);
    frame();
    k_first = (kills.size() > 0) ? kills[0] : -1;
    k_last  = (kills.size() > 3) ? kills[3] : -1;
    check("all_count", 32'(kills.size()),    32'd4);
    check("all_first", 32'(k_first),         32'(sof_cyc + 1));
    check("all_last",  32'(k_last),          32'(sof_cyc + 4));
    check("all_alive", 32'(bus.enemy_alive), 32'h0);
    check("all_dying", 32'(bus.enemy_dying), 32'hF);
    check("all_dir",   32'(bus.dir_code),    32'h0);
    repeat (15) frame();
    check("all_dying15", 32'(bus.enemy_dying), 32'hF);
    check("all_clear15", 32'(bus.level_clear), 32'h0);
    frame();
    check("all_dying16", 32'(bus.enemy_dying), 32'h0);
    check("all_clear16", 32'(bus.level_clear), 32'h1);
    frame();
    check("idle_clear", 32'(bus.level_clear), 32'h1);
    check("idle_kills", 32'(kills.size()),    32'd4);

    // Asynchronous reset in the middle of a sweep.
    start_game();
    check("g_clear", 32'(bus.level_clear), 32'h0);
    @(negedge clk) bus.startOfFrame = 1'b1;
    @(negedge clk) bus.startOfFrame = 1'b0;
    @(negedge clk);
    #2 resetN = 1'b1;
    #1 check_all_zero("midreset");
    @(negedge clk) resetN = 1'b0;

    // LFSR restarts from the seed: enemy 3's first re-roll follows the reference again.
    start_game();
    repeat (8) frame();
    exp_dir     = 16'h1111;
    exp_dir[3]  = ref_dir(upd_lfsr[3][1:0]);
    exp_rand    = '0;
    exp_rand[3] = upd_lfsr[3][2];
    check("restart_dir",  32'(bus.dir_code), 32'(exp_dir));
    check("restart_rand", 32'(bus.random),   32'(exp_rand));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
